// File: rtl/qmac_vec.sv
// qmac_vec: multi-lane quantized MAC engine.
// Accumulates the sum of LANES signed products over a programmed number of beats into a
// saturating accumulator, then requantizes with round-half-up arithmetic shift and clamp.
module qmac_vec #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned LANES = 4,
  parameter int unsigned ACC_W = 32,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned LEN_W = 10
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    start_i,
  input  logic [LEN_W-1:0]        len_i,
  input  logic [4:0]              shift_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [LANES*IN_W-1:0]   act_i,
  input  logic [LANES*IN_W-1:0]   wgt_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [ACC_W-1:0]        acc_o,
  output logic [OUT_W-1:0]        q_o,
  output logic                    sat_o,
  output logic                    busy_o
);

  localparam int unsigned PRODW = 2 * IN_W;
  localparam int unsigned PW    = 2 * IN_W + $clog2(LANES);

  // Requant clamp bounds, sign-extended to the ACC_W+1 working width.
  localparam logic signed [ACC_W:0] QMAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] QMIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StAcc, StDrain, StReq, StOut} state_e;

  state_e                   r_state, w_state_d;
  logic [LEN_W-1:0]         r_cnt;
  logic [4:0]               r_shift;
  logic                     r_drain;
  logic                     r_s1_vld;
  logic [LANES*IN_W-1:0]    r_act, r_wgt;
  logic                     r_p_vld;
  logic signed [PW-1:0]     r_p;
  logic [ACC_W-1:0]         r_acc;
  logic                     r_sat;
  logic [OUT_W-1:0]         r_q;

  logic                     w_in_ready, w_out_valid, w_busy;
  logic                     w_start, w_accept;
  logic signed [IN_W-1:0]   w_a, w_b;
  logic signed [PRODW-1:0]  w_prod;
  logic signed [PW-1:0]     w_psum;
  logic signed [ACC_W:0]    w_acc_sum;
  logic                     w_acc_ovf;
  logic [ACC_W-1:0]         w_acc_nxt;
  logic [ACC_W:0]           w_half;
  logic signed [ACC_W:0]    w_rnd, w_r;
  logic [OUT_W-1:0]         w_q;

  // Next-state and handshake decode.
  always_comb begin
    w_state_d   = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_busy      = 1'b1;
    unique case (r_state)
      StIdle: begin
        w_busy = 1'b0;
        if (start_i) w_state_d = (len_i == '0) ? StDrain : StAcc;
      end
      StAcc: begin
        w_in_ready = 1'b1;
        if (in_valid_i && (r_cnt == LEN_W'(1))) w_state_d = StDrain;
      end
      // Product and accumulate stages take a fixed two cycles to empty.
      StDrain: if (r_drain) w_state_d = StReq;
      StReq:   w_state_d = StOut;
      StOut: begin
        w_out_valid = 1'b1;
        if (out_ready_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_start  = (r_state == StIdle) && start_i;
  assign w_accept = w_in_ready && in_valid_i;

  // Sum of lane products at full precision; cannot overflow PW bits.
  always_comb begin
    w_psum = '0;
    w_a    = '0;
    w_b    = '0;
    w_prod = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      w_a    = r_act[k*IN_W +: IN_W];
      w_b    = r_wgt[k*IN_W +: IN_W];
      w_prod = PRODW'(w_a) * PRODW'(w_b);
      w_psum = w_psum + PW'(w_prod);
    end
  end

  // Saturating accumulate: overflow shows as disagreement of the top two bits.
  always_comb begin
    w_acc_sum = $signed({r_acc[ACC_W-1], r_acc}) + $signed({{(ACC_W+1-PW){r_p[PW-1]}}, r_p});
    w_acc_ovf = w_acc_sum[ACC_W] ^ w_acc_sum[ACC_W-1];
    w_acc_nxt = w_acc_sum[ACC_W-1:0];
    if (w_acc_ovf) begin
      w_acc_nxt = w_acc_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Requantize: round-half-up arithmetic shift, then clamp to OUT_W.
  always_comb begin
    w_half = '0;
    if ((r_shift != 5'd0) && (32'(r_shift) < ACC_W)) begin
      w_half = (ACC_W+1)'(1) << (r_shift - 5'd1);
    end
    w_rnd = $signed({r_acc[ACC_W-1], r_acc}) + $signed(w_half);
    if (32'(r_shift) >= ACC_W) w_r = {(ACC_W+1){r_acc[ACC_W-1]}};
    else                       w_r = w_rnd >>> r_shift;
    if (w_r > QMAX)      w_q = QMAX[OUT_W-1:0];
    else if (w_r < QMIN) w_q = QMIN[OUT_W-1:0];
    else                 w_q = w_r[OUT_W-1:0];
  end

  // Control state: FSM, beat counter, captured shift, drain timer.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_shift <= '0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_cnt   <= len_i;
        r_shift <= shift_i;
      end else if (w_accept) begin
        r_cnt <= r_cnt - LEN_W'(1);
      end
      r_drain <= (r_state == StDrain) ? ~r_drain : 1'b0;
    end
  end

  // Operand capture and product stage.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_s1_vld <= 1'b0;
      r_act    <= '0;
      r_wgt    <= '0;
      r_p_vld  <= 1'b0;
      r_p      <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_act <= act_i;
        r_wgt <= wgt_i;
      end
      r_p_vld <= r_s1_vld;
      if (r_s1_vld) r_p <= w_psum;
    end
  end

  // Accumulator, sticky saturation flag and requantized result.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc <= '0;
      r_sat <= 1'b0;
      r_q   <= '0;
    end else begin
      if (w_start) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (r_p_vld) begin
        r_acc <= w_acc_nxt;
        if (w_acc_ovf) r_sat <= 1'b1;
      end
      if (r_state == StReq) r_q <= w_q;
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign busy_o      = w_busy;
  assign acc_o       = r_acc;
  assign q_o         = r_q;
  assign sat_o       = r_sat;

endmodule
